adc_capture_pack: RTL and testbench

- Sits directly downstream of the axi_ad9361 RX core (adc_clk domain) and upstream of the RX DMA / DDR3 write path.
- Accepts per-sample I0/Q0 ADC words gated by channel enables and packs them into 64-bit beats.
- Buffers the beats in a FIFO and streams a capture of programmed length out on an AXI-Stream master, with tlast on the final beat.

---
 rtl/adc_capture_pack_if.sv | 9 +
 rtl/adc_capture_pack.sv | 125 ++++++++++++
 tb/tb_adc_capture_pack.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/adc_capture_pack_if.sv
// adc_capture_pack_if: 64-bit AXI-Stream link carrying packed ADC beats with tlast.
interface adc_capture_pack_if;
    logic [63:0] tdata;
    logic tvalid;
    logic tready;
    logic tlast;
    modport master(output tdata, tvalid, tlast, input tready);
    modport slave(input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/adc_capture_pack.sv
// adc_capture_pack: packs I0/Q0 ADC samples into 64-bit beats and streams a fixed-length capture over AXI-Stream.
// Define ADC_CAPTURE_PACK_TRIGGER_EN to add capture_trig and an ARMED state that waits for its rising edge.
module adc_capture_pack #(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_WIDTH = 24
) (
    input  logic adc_clk,
    input  logic adc_resetn,
    input  logic adc_valid,
    input  logic adc_enable_i0,
    input  logic adc_enable_q0,
    input  logic [15:0] adc_data_i0,
    input  logic [15:0] adc_data_q0,
    input  logic capture_start,
    input  logic [CNT_WIDTH-1:0] capture_len,
`ifdef ADC_CAPTURE_PACK_TRIGGER_EN
    input  logic capture_trig,
`endif
    output logic capture_busy,
    output logic capture_ovf,
    adc_capture_pack_if.master m_axis
);
    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef ADC_CAPTURE_PACK_TRIGGER_EN
    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DRAIN} state_t;
`else
    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;
`endif
    state_t state, state_nxt;
    logic en_i, en_q;
    logic [CNT_WIDTH-1:0] len_q, beat_cnt;
    logic [1:0] slot;
    logic [63:0] pack, pack_nxt, push_data;
    logic push_q;
    logic [64:0] mem [FIFO_DEPTH];
    logic [64:0] head;
    logic [AW:0] wr_ptr, rd_ptr;
    logic accept, sample, last_slot, full, empty, pop, drop, push_ok, last_beat;

    assign accept = state == IDLE && capture_start && capture_len != '0 && (adc_enable_i0 || adc_enable_q0);
    assign sample = state == CAPTURE && adc_valid;
    assign last_slot = slot == ((en_i && en_q) ? 2'd1 : 2'd3);
    assign empty = wr_ptr == rd_ptr;
    assign full = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
    assign pop = !empty && m_axis.tready;
    // A full FIFO still takes the push when the head pops in the same cycle.
    assign drop = push_q && full && !pop;
    assign push_ok = push_q && !drop;
    assign last_beat = beat_cnt + CNT_WIDTH'(1) == len_q;
    assign head = mem[rd_ptr[AW-1:0]];

    assign capture_busy = state != IDLE;
    assign m_axis.tvalid = !empty;
    assign m_axis.tdata = empty ? '0 : head[63:0];
    assign m_axis.tlast = !empty && head[64];

`ifdef ADC_CAPTURE_PACK_TRIGGER_EN
    logic trig_q, trig_rise;
    assign trig_rise = capture_trig && !trig_q;
    always_ff @(posedge adc_clk or negedge adc_resetn)
        if (!adc_resetn) trig_q <= 1'b0;
        else trig_q <= capture_trig;
`endif

    always_comb begin
        pack_nxt = pack;
        if (en_i && en_q) pack_nxt[32*slot[0] +: 32] = {adc_data_q0, adc_data_i0};
        else pack_nxt[16*slot +: 16] = en_i ? adc_data_i0 : adc_data_q0;
    end

    always_comb begin
        state_nxt = state;
        case (state)
`ifdef ADC_CAPTURE_PACK_TRIGGER_EN
            IDLE:    if (accept) state_nxt = ARMED;
            ARMED:   if (trig_rise) state_nxt = CAPTURE;
`else
            IDLE:    if (accept) state_nxt = CAPTURE;
`endif
            CAPTURE: if (push_ok && last_beat) state_nxt = DRAIN;
            DRAIN:   if (pop && head[64]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge adc_clk or negedge adc_resetn)
        if (!adc_resetn) state <= IDLE;
        else state <= state_nxt;

    always_ff @(posedge adc_clk or negedge adc_resetn)
        if (!adc_resetn) begin
            en_i <= 1'b0;
            en_q <= 1'b0;
            len_q <= '0;
            beat_cnt <= '0;
            slot <= '0;
            push_q <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            capture_ovf <= 1'b0;
        end else begin
            push_q <= sample && last_slot;
            if (sample) slot <= last_slot ? 2'd0 : slot + 2'd1;
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
                beat_cnt <= beat_cnt + CNT_WIDTH'(1);
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (drop) capture_ovf <= 1'b1;
            if (accept) begin
                en_i <= adc_enable_i0;
                en_q <= adc_enable_q0;
                len_q <= capture_len;
                beat_cnt <= '0;
                slot <= '0;
                capture_ovf <= 1'b0;
            end
        end

    always_ff @(posedge adc_clk) begin
        if (sample) pack <= pack_nxt;
        if (sample && last_slot) push_data <= pack_nxt;
        if (push_ok) mem[wr_ptr[AW-1:0]] <= {last_beat, push_data};
    end
endmodule

// File: tb/tb_adc_capture_pack.sv
// tb_adc_capture_pack: randomized capture runs scored against a sample-queue packing model.
module tb_adc_capture_pack;
    logic adc_clk, adc_resetn, adc_valid, adc_enable_i0, adc_enable_q0, capture_start;
    logic [15:0] adc_data_i0, adc_data_q0;
    logic [23:0] capture_len;
    logic capture_busy, capture_ovf;
    int n_chk = 0, n_err = 0, cyc = 0, last_hs = -10;
    logic [63:0] rx_data [$];
    logic rx_last [$];

    adc_capture_pack_if axis();

    adc_capture_pack #(.FIFO_DEPTH(4), .CNT_WIDTH(24)) dut (
        .adc_clk(adc_clk),
        .adc_resetn(adc_resetn),
        .adc_valid(adc_valid),
        .adc_enable_i0(adc_enable_i0),
        .adc_enable_q0(adc_enable_q0),
        .adc_data_i0(adc_data_i0),
        .adc_data_q0(adc_data_q0),
        .capture_start(capture_start),
        .capture_len(capture_len),
        .capture_busy(capture_busy),
        .capture_ovf(capture_ovf),
        .m_axis(axis)
    );

    initial adc_clk = 1'b0;
    always #5 adc_clk = ~adc_clk;
    always @(posedge adc_clk) cyc <= cyc + 1;

    always @(negedge adc_clk)
        if (axis.tvalid && axis.tready) begin
            rx_data.push_back(axis.tdata);
            rx_last.push_back(axis.tlast);
            if (axis.tlast) last_hs = cyc;
        end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_capture(input int len, input bit ei, input bit eq, input int vpct, input int rpct,
                               input bit rnd, input logic [15:0] ib, input logic [15:0] qb,
                               input int hold, input bit mid, input bit exp_ovf);
        logic [31:0] samp [$];
        logic [15:0] di, dq;
        logic [63:0] exp_beat;
        int n = 0, fall = -1, spb;
        spb = (ei && eq) ? 2 : 4;
        rx_data.delete();
        rx_last.delete();
        @(posedge adc_clk); #1;
        adc_enable_i0 = ei;
        adc_enable_q0 = eq;
        capture_len = 24'(len);
        capture_start = 1'b1;
        for (int c = 0; c < 3000 && fall < 0; c++) begin
            @(posedge adc_clk); #1;
            capture_start = mid && c == 4;
            capture_len = (mid && c == 4) ? 24'd5 : 24'(len);
            if (rnd) begin
                adc_enable_i0 = 1'($urandom);
                adc_enable_q0 = 1'($urandom);
            end
            axis.tready = c < hold ? 1'b0 : $urandom_range(99) < rpct;
            adc_valid = $urandom_range(99) < vpct;
            di = rnd ? 16'($urandom) : ib + 16'(n);
            dq = rnd ? 16'($urandom) : qb + 16'(n);
            adc_data_i0 = di;
            adc_data_q0 = dq;
            if (adc_valid) begin
                samp.push_back((ei && eq) ? {dq, di} : {16'h0, ei ? di : dq});
                n++;
            end
            @(negedge adc_clk); #1;
            if (c == 0) check("busy_set", capture_busy, 1);
            if (hold > 0 && c == hold - 1) begin
                check("ovf_set", capture_ovf, 1);
                check("held_beats", rx_data.size(), 0);
                check("held_tvalid", axis.tvalid, 1);
            end
            if (!capture_busy) fall = cyc;
        end
        adc_valid = 1'b0;
        capture_start = 1'b0;
        check("done", fall >= 0, 1);
        check("busy_fall", fall, last_hs + 1);
        check("nbeats", rx_data.size(), len);
        check("ovf", capture_ovf, exp_ovf);
        for (int b = 0; b < rx_data.size() && b < len; b++) begin
            check("tlast", rx_last[b], b == len - 1);
            if (hold == 0) begin
                check("enough_samples", samp.size() >= spb * (b + 1), 1);
                if (samp.size() >= spb * (b + 1)) begin
                    exp_beat = (spb == 2) ? {samp[2*b+1], samp[2*b]}
                             : {samp[4*b+3][15:0], samp[4*b+2][15:0], samp[4*b+1][15:0], samp[4*b][15:0]};
                    check("beat_data", rx_data[b], exp_beat);
                end
            end
        end
    endtask

    task automatic bad_start(input int len, input bit ei, input bit eq);
        logic seen = 1'b0;
        @(posedge adc_clk); #1;
        adc_enable_i0 = ei;
        adc_enable_q0 = eq;
        capture_len = 24'(len);
        capture_start = 1'b1;
        @(posedge adc_clk); #1;
        capture_start = 1'b0;
        adc_valid = 1'b1;
        axis.tready = 1'b1;
        repeat (6) begin
            @(negedge adc_clk); #1;
            seen |= capture_busy | axis.tvalid;
        end
        adc_valid = 1'b0;
        check("ignored_start", seen, 0);
    endtask

    initial begin
        logic [1:0] en;
        int nb;
        adc_resetn = 1'b0;
        adc_valid = 1'b0;
        adc_enable_i0 = 1'b0;
        adc_enable_q0 = 1'b0;
        adc_data_i0 = '0;
        adc_data_q0 = '0;
        capture_start = 1'b0;
        capture_len = '0;
        axis.tready = 1'b0;
        repeat (3) @(negedge adc_clk);
        #1;
        check("rst_busy", capture_busy, 0);
        check("rst_ovf", capture_ovf, 0);
        check("rst_tvalid", axis.tvalid, 0);
        check("rst_tlast", axis.tlast, 0);
        check("rst_tdata", axis.tdata, 0);
        @(negedge adc_clk);
        adc_resetn = 1'b1;

        run_capture(3, 1, 1, 100, 100, 0, 16'h0001, 16'h8001, 0, 0, 0);
        check("t1_beat0", rx_data[0], 64'h8002_0002_8001_0001);
        run_capture(2, 1, 0, 100, 100, 0, 16'h0010, 16'hABC0, 0, 0, 0);
        check("t2_beat0", rx_data[0], 64'h0013_0012_0011_0010);
        check("t2_beat1", rx_data[1], 64'h0017_0016_0015_0014);
        run_capture(8, 1, 1, 100, 100, 0, 16'h0001, 16'h8001, 30, 0, 1);
        check("ovf_sticky", capture_ovf, 1);
        run_capture(3, 1, 1, 50, 100, 0, 16'h0100, 16'h0200, 0, 1, 0);
        bad_start(0, 1, 1);
        bad_start(3, 0, 0);

        @(posedge adc_clk); #1;
        rx_data.delete();
        rx_last.delete();
        adc_enable_i0 = 1'b1;
        adc_enable_q0 = 1'b1;
        capture_len = 24'd5;
        capture_start = 1'b1;
        @(posedge adc_clk); #1;
        capture_start = 1'b0;
        adc_valid = 1'b1;
        axis.tready = 1'b1;
        for (int c = 0; c < 100 && rx_data.size() < 2; c++) begin
            @(negedge adc_clk); #1;
        end
        adc_resetn = 1'b0;
        #1;
        nb = rx_data.size();
        check("mid_rst_beats", nb >= 2, 1);
        check("mid_rst_busy", capture_busy, 0);
        check("mid_rst_ovf", capture_ovf, 0);
        check("mid_rst_tvalid", axis.tvalid, 0);
        check("mid_rst_tlast", axis.tlast, 0);
        check("mid_rst_tdata", axis.tdata, 0);
        adc_valid = 1'b0;
        repeat (2) @(negedge adc_clk);
        check("no_partial", rx_data.size(), nb);
        adc_resetn = 1'b1;
        run_capture(1, 1, 1, 100, 100, 0, 16'h0A00, 16'h0B00, 0, 0, 0);

        for (int t = 0; t < 10; t++) begin
            en = 2'($urandom_range(1, 3));
            run_capture($urandom_range(1, 6), en[0], en[1], en == 2'd3 ? 33 : 50, 75, 1, 16'h0, 16'h0, 0, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
